pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage; successor to the single-register PC. Holds the fetch address and advances it by a fixed step each cycle. Supports stall, exception vectoring, jump, branch and call/return redirection through an optional return-address stack (RAS). Flags every non-sequential update so the pipeline can flush.

---
 rtl/pc_unit.sv | 120 ++++++++++++
 tb/tb_pc_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, exception, jump, branch and call/return.
// Define PC_UNIT_RAS_EN to build the return-address stack.
module pc_unit #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = 'h4,
    parameter int unsigned      INC       = 2,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_pause,
    input  logic             exc,
    input  logic             ret,
    input  logic             call,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             redirect,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    assign pc_next_seq = pc_out + WIDTH'(INC);

`ifdef PC_UNIT_RAS_EN
    localparam int unsigned     PW   = $clog2(RAS_DEPTH);
    localparam logic [PW:0]     FULL = (PW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    top;
    logic [PW:0]      count;
    logic             err;
    logic [PW-1:0]    top_inc;

    assign top_inc   = top + 1'b1;
    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL);
    assign ras_err   = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out   <= RESET_VEC;
            redirect <= 1'b0;
            top      <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else if (pc_pause) begin
            redirect <= 1'b0;
        end else if (exc) begin
            pc_out   <= EXC_VEC;
            redirect <= 1'b1;
        end else if (ret) begin
            if (count != '0) begin
                pc_out   <= ras_mem[top];
                top      <= top - 1'b1;
                count    <= count - 1'b1;
                redirect <= 1'b1;
            end else begin
                pc_out   <= pc_next_seq;
                err      <= 1'b1;
                redirect <= 1'b0;
            end
        end else if (call) begin
            // when full the slot above top holds the oldest entry
            pc_out           <= jump_target;
            ras_mem[top_inc] <= pc_next_seq;
            top              <= top_inc;
            if (count == FULL)
                err <= 1'b1;
            else
                count <= count + 1'b1;
            redirect <= 1'b1;
        end else if (jump) begin
            pc_out   <= jump_target;
            redirect <= 1'b1;
        end else if (branch_taken) begin
            pc_out   <= branch_target;
            redirect <= 1'b1;
        end else begin
            pc_out   <= pc_next_seq;
            redirect <= 1'b0;
        end
    end
`else
    localparam int unsigned unused_depth = RAS_DEPTH;
    logic unused_ret;

    assign unused_ret = ret;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out   <= RESET_VEC;
            redirect <= 1'b0;
        end else if (pc_pause) begin
            redirect <= 1'b0;
        end else if (exc) begin
            pc_out   <= EXC_VEC;
            redirect <= 1'b1;
        end else if (call || jump) begin
            pc_out   <= jump_target;
            redirect <= 1'b1;
        end else if (branch_taken) begin
            pc_out   <= branch_target;
            redirect <= 1'b1;
        end else begin
            pc_out   <= pc_next_seq;
            redirect <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios followed by random traffic
// against a queue-based reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, pc_pause, exc, ret, call, jump, branch_taken;
    logic [15:0] jump_target, branch_target;
    logic [15:0] pc_out, pc_next_seq;
    logic        redirect, ras_empty, ras_full, ras_err;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH(16), .RESET_VEC(16'h0000), .EXC_VEC(16'h0004),
        .INC(2), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .pc_pause(pc_pause), .exc(exc),
        .ret(ret), .call(call), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc_out(pc_out), .pc_next_seq(pc_next_seq), .redirect(redirect),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    typedef struct {
        int pc;
        bit red;
        bit empty;
        bit full;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    // reference model state
    int   m_pc = 0;
    bit   m_red = 0;
    bit   m_err = 0;
    int   stk[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, expv, $time);
    endtask

    task automatic model(input bit r, input bit p, input bit e,
                         input bit rt, input bit c, input bit j,
                         input int jt, input bit b, input int bt);
        if (r) begin
            m_pc = 0; m_red = 0; m_err = 0; stk.delete();
        end else if (p) begin
            m_red = 0;
        end else if (e) begin
            m_pc = 4; m_red = 1;
`ifdef PC_UNIT_RAS_EN
        end else if (rt) begin
            if (stk.size() > 0) begin
                m_pc = stk.pop_back(); m_red = 1;
            end else begin
                m_pc = (m_pc + 2) % 65536; m_err = 1; m_red = 0;
            end
        end else if (c) begin
            stk.push_back((m_pc + 2) % 65536);
            if (stk.size() > 4) begin
                void'(stk.pop_front());
                m_err = 1;
            end
            m_pc = jt; m_red = 1;
`endif
        end else if (j || c) begin
            m_pc = jt; m_red = 1;
        end else if (b) begin
            m_pc = bt; m_red = 1;
        end else begin
            m_pc = (m_pc + 2) % 65536; m_red = 0;
        end
    endtask

    task automatic drive(input bit r, input bit p, input bit e,
                         input bit rt, input bit c, input bit j,
                         input int jt, input bit b, input int bt);
        exp_t x;
        @(negedge clk);
        #1;
        rst = r; pc_pause = p; exc = e; ret = rt; call = c; jump = j;
        jump_target = 16'(jt); branch_taken = b; branch_target = 16'(bt);
        model(r, p, e, rt, c, j, jt, b, bt);
        x.pc = m_pc; x.red = m_red; x.err = m_err;
        x.empty = (stk.size() == 0);
        x.full = (stk.size() == 4);
        exp_q.push_back(x);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jmp(input int t);
        drive(0, 0, 0, 0, 0, 1, t, 0, 0);
    endtask

    task automatic cal(input int t);
        drive(0, 0, 0, 0, 1, 0, t, 0, 0);
    endtask

    task automatic rtn();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    // monitor: each negedge presents the state produced by the previous edge
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("pc_out", 32'(pc_out), 32'(x.pc));
            chk("pc_next_seq", 32'(pc_next_seq), 32'((x.pc + 2) % 65536));
            chk("redirect", 32'(redirect), 32'(x.red));
            chk("ras_empty", 32'(ras_empty), 32'(x.empty));
            chk("ras_full", 32'(ras_full), 32'(x.full));
            chk("ras_err", 32'(ras_err), 32'(x.err));
        end
    end

    initial begin
        rst = 1; pc_pause = 0; exc = 0; ret = 0; call = 0; jump = 0;
        jump_target = '0; branch_taken = 0; branch_target = '0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle();

        jmp(16'h0100);
        drive(0, 1, 0, 0, 0, 1, 16'h0200, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 16'h0200, 0, 0);
        jmp(16'h0200);
        idle();

        jmp(16'h0010);
        cal(16'h0400);
        rtn();
        idle();

        jmp(16'h0000);
        for (int i = 1; i <= 5; i++) cal(i * 16'h1000);
        repeat (5) rtn();

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cal(16'h0600);
        drive(0, 0, 1, 1, 0, 1, 16'h0700, 1, 16'h0800);
        rtn();

        jmp(16'hFFFE);
        idle();
        idle();

        cal(16'h0A00);
        cal(16'h0B00);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(7) == 0,
                  $urandom_range(15) == 0, $urandom_range(4) == 0,
                  $urandom_range(4) == 0, $urandom_range(5) == 0,
                  int'($urandom_range(65535)), $urandom_range(3) == 0,
                  int'($urandom_range(65535)));
        end

        idle();
        repeat (3) @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
